// File: rtl/unidade_execucao_matriz_if.sv
// Decoder-to-execution-stage bus: decoded instruction fields under a
// valid/ready handshake, plus read data and completion/error pulses back.
interface unidade_execucao_matriz_if #(
  parameter int unsigned LARGURA_DADO = 16
);
  logic                    instr_valida;
  logic [3:0]              opcode;
  logic [2:0]              linha;
  logic [2:0]              coluna;
  logic [LARGURA_DADO-1:0] dado;
  logic [1:0]              id_matriz;
  logic                    pronto;
  logic [LARGURA_DADO-1:0] resultado;
  logic                    resultado_valido;
  logic                    concluido;
  logic                    erro;

  // Controller / decoder side
  modport master (
    output instr_valida, opcode, linha, coluna, dado, id_matriz,
    input  pronto, resultado, resultado_valido, concluido, erro
  );

  // Execution unit side
  modport slave (
    input  instr_valida, opcode, linha, coluna, dado, id_matriz,
    output pronto, resultado, resultado_valido, concluido, erro
  );
endinterface

// File: rtl/unidade_execucao_matriz.sv
// Matrix execution stage: executes NOP/LOAD/STORE in one cycle and
// CLEAR/FILL as a 64-cycle row-major sweep over one matrix of the bank.
module unidade_execucao_matriz #(
  parameter int unsigned LARGURA_DADO = 16,
  parameter int unsigned NUM_MATRIZES = 4,
  parameter int unsigned DIM          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  unidade_execucao_matriz_if.slave  bus
);

  localparam int unsigned PROF = NUM_MATRIZES * DIM * DIM;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_CLEAR = 4'b0011;
  localparam logic [3:0] OP_FILL  = 4'b0100;

  typedef enum logic [1:0] {
    OCIOSO,
    EXECUTA,
    VARREDURA
  } estado_t;

  estado_t estado, proximo;

  logic [LARGURA_DADO-1:0] banco [PROF];

  logic [3:0]              op_r;
  logic [2:0]              linha_r;
  logic [2:0]              coluna_r;
  logic [LARGURA_DADO-1:0] dado_r;
  logic [1:0]              id_r;
  logic [5:0]              cnt;

  logic aceita;
  logic eh_varredura;
  logic fim_varredura;

  assign aceita        = bus.instr_valida && (estado == OCIOSO);
  assign eh_varredura  = (bus.opcode == OP_CLEAR) || (bus.opcode == OP_FILL);
  assign fim_varredura = (estado == VARREDURA) && (cnt == 6'd63);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Next-state logic and ready indication
  always_comb begin
    proximo    = estado;
    bus.pronto = 1'b0;
    unique case (estado)
      OCIOSO: begin
        bus.pronto = 1'b1;
        if (bus.instr_valida) proximo = eh_varredura ? VARREDURA : EXECUTA;
      end
      EXECUTA:   proximo = OCIOSO;
      VARREDURA: if (cnt == 6'd63) proximo = OCIOSO;
      default:   proximo = OCIOSO;
    endcase
  end

  // Latch decoded fields on accept; sweep counter runs only during a sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= '0;
      linha_r  <= '0;
      coluna_r <= '0;
      dado_r   <= '0;
      id_r     <= '0;
      cnt      <= '0;
    end else begin
      if (aceita) begin
        op_r     <= bus.opcode;
        linha_r  <= bus.linha;
        coluna_r <= bus.coluna;
        dado_r   <= bus.dado;
        id_r     <= bus.id_matriz;
      end
      if (estado == VARREDURA) cnt <= cnt + 6'd1;
      else                     cnt <= '0;
    end
  end

  // Matrix bank: single-element STORE or one sweep element per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PROF; i++) banco[i] <= '0;
    end else begin
      if (estado == EXECUTA && op_r == OP_STORE)
        banco[{id_r, linha_r, coluna_r}] <= dado_r;
      else if (estado == VARREDURA)
        banco[{id_r, cnt}] <= (op_r == OP_FILL) ? dado_r : '0;
    end
  end

  // Registered result and single-cycle status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.resultado        <= '0;
      bus.resultado_valido <= 1'b0;
      bus.concluido        <= 1'b0;
      bus.erro             <= 1'b0;
    end else begin
      bus.resultado_valido <= 1'b0;
      bus.concluido        <= 1'b0;
      bus.erro             <= 1'b0;
      if (estado == EXECUTA) begin
        bus.concluido <= 1'b1;
        case (op_r)
          OP_NOP, OP_STORE: ;
          OP_LOAD: begin
            bus.resultado        <= banco[{id_r, linha_r, coluna_r}];
            bus.resultado_valido <= 1'b1;
          end
          default: bus.erro <= 1'b1;
        endcase
      end else if (fim_varredura) begin
        bus.concluido <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unidade_execucao_matriz.sv
// Directed bench for the matrix execution stage.
module tb_unidade_execucao_matriz;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  unidade_execucao_matriz_if #(.LARGURA_DADO(16)) bus ();

  unidade_execucao_matriz #(
    .LARGURA_DADO(16),
    .NUM_MATRIZES(4),
    .DIM(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction at a negedge; returns #1 after the accept edge
  task automatic send(input logic [3:0] op, input logic [2:0] l, input logic [2:0] c,
                      input logic [15:0] d, input logic [1:0] id);
    @(negedge clk);
    bus.opcode = op; bus.linha = l; bus.coluna = c; bus.dado = d; bus.id_matriz = id;
    bus.instr_valida = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valida = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [2:0] l,
                        input logic [2:0] c, input logic [15:0] d, input logic [1:0] id,
                        input logic rv, input logic er, input logic [15:0] res);
    send(op, l, c, d, id);
    chk({tag, "_early_conc"}, 32'(bus.concluido), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_conc"}, 32'(bus.concluido), 32'd1);
    chk({tag, "_rv"}, 32'(bus.resultado_valido), 32'(rv));
    chk({tag, "_erro"}, 32'(bus.erro), 32'(er));
    chk({tag, "_res"}, 32'(bus.resultado), 32'(res));
    chk({tag, "_pronto"}, 32'(bus.pronto), 32'd1);
  endtask

  task automatic load(input string tag, input logic [2:0] l, input logic [2:0] c,
                      input logic [1:0] id, input logic [15:0] exp);
    single(tag, 4'b0001, l, c, 16'h0, id, 1'b1, 1'b0, exp);
  endtask

  // Bounded wait for the end of a sweep; counts cycles and busy samples
  task automatic sweep(input string tag, input logic [3:0] op, input logic [15:0] d,
                       input logic [1:0] id);
    int n = 0;
    int low = 0;
    send(op, 3'd5, 3'd5, d, id);
    while (!bus.concluido && n < 100) begin
      if (!bus.pronto) low++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_cycles"}, 32'(n), 32'd64);
    chk({tag, "_busy"}, 32'(low), 32'd64);
    chk({tag, "_pronto"}, 32'(bus.pronto), 32'd1);
  endtask

  initial begin
    bus.instr_valida = 1'b0; bus.opcode = '0; bus.linha = '0;
    bus.coluna = '0; bus.dado = '0; bus.id_matriz = '0;
    #1;
    chk("rst_pronto", 32'(bus.pronto), 32'd1);
    chk("rst_res", 32'(bus.resultado), 32'd0);
    chk("rst_rv", 32'(bus.resultado_valido), 32'd0);
    chk("rst_conc", 32'(bus.concluido), 32'd0);
    chk("rst_erro", 32'(bus.erro), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: load from a freshly reset bank
    load("t1_load", 3'd2, 3'd5, 2'd1, 16'h0000);

    // 2: store then load, neighbour untouched
    single("t2_store", 4'b0010, 3'd1, 3'd4, 16'h1234, 2'd1, 1'b0, 1'b0, 16'h0000);
    load("t2_load", 3'd1, 3'd4, 2'd1, 16'h1234);
    load("t2_neigh", 3'd1, 3'd3, 2'd1, 16'h0000);

    // NOP keeps resultado
    single("nop", 4'b0000, 3'd0, 3'd0, 16'hFFFF, 2'd0, 1'b0, 1'b0, 16'h0000);

    // 3: fill M2
    sweep("t3_fill", 4'b0100, 16'hABCD, 2'd2);
    @(posedge clk); #1;
    chk("t3_conc_width", 32'(bus.concluido), 32'd0);
    load("t3_first", 3'd0, 3'd0, 2'd2, 16'hABCD);
    load("t3_last", 3'd7, 3'd7, 2'd2, 16'hABCD);
    load("t3_other", 3'd0, 3'd0, 2'd3, 16'h0000);

    // 4: clear M2 (dado must be ignored)
    sweep("t4_clear", 4'b0011, 16'hFFFF, 2'd2);
    load("t4_m2", 3'd3, 3'd3, 2'd2, 16'h0000);
    load("t4_m1", 3'd1, 3'd4, 2'd1, 16'h1234);

    // 5: illegal opcodes leave resultado and bank alone
    single("t5_op15", 4'b1111, 3'd1, 3'd4, 16'h5555, 2'd1, 1'b0, 1'b1, 16'h1234);
    single("t5_op5", 4'b0101, 3'd1, 3'd4, 16'h6666, 2'd1, 1'b0, 1'b1, 16'h1234);
    load("t5_bank", 3'd1, 3'd4, 2'd1, 16'h1234);
    @(posedge clk); #1;
    chk("t5_rv_width", 32'(bus.resultado_valido), 32'd0);

    // instr_valida held high during a sweep must not be accepted
    begin
      int n = 0;
      send(4'b0100, 3'd0, 3'd0, 16'h1111, 2'd3);
      bus.opcode = 4'b0010; bus.linha = 3'd5; bus.coluna = 3'd5;
      bus.dado = 16'h9999; bus.id_matriz = 2'd3;
      bus.instr_valida = 1'b1;
      while (!bus.concluido && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      bus.instr_valida = 1'b0;
      chk("hold_cycles", 32'(n), 32'd64);
    end
    load("hold_m3", 3'd5, 3'd5, 2'd3, 16'h1111);

    // 6: reset in the middle of a sweep
    send(4'b0100, 3'd0, 3'd0, 16'h5555, 2'd0);
    repeat (30) @(posedge clk);
    #2;
    chk("t6_busy", 32'(bus.pronto), 32'd0);
    reset = 1'b1;
    #1;
    chk("t6_pronto", 32'(bus.pronto), 32'd1);
    chk("t6_res", 32'(bus.resultado), 32'd0);
    chk("t6_conc", 32'(bus.concluido), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    load("t6_m0", 3'd0, 3'd0, 2'd0, 16'h0000);
    load("t6_m1", 3'd1, 3'd4, 2'd1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
